// File: rtl/cache_setassoc.sv
// cache_setassoc: N-way set-associative read-only cache with a line-wide refill port.
// Hits return data in the request cycle. A miss latches the tag and index and runs one
// line refill, after which the request hits.
// Optional build macro CACHE_STATS_EN adds wrapping hit and miss counters.
//
// state   | meaning
// IDLE    | serve hits, detect misses, apply flushes
// REFILL  | request the missed line from memory and write it into the victim way
module cache_setassoc #(
  parameter int AddrWidth    = 32,
  parameter int NrSets       = 64,
  parameter int NrWays       = 2,
  parameter int WordsPerLine = 4
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [AddrWidth-1:0]      addr_i,
  input  logic                      read_en_i,
  output logic                      read_valid_o,
  output logic [31:0]               read_word_o,
  input  logic                      flush_i,
  output logic [AddrWidth-1:0]      mem_addr_o,
  output logic                      mem_read_en_o,
  input  logic                      mem_read_valid_i,
  input  logic [32*WordsPerLine-1:0] mem_read_data_i
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]               hit_count_o,
  output logic [31:0]               miss_count_o
`endif
);

  localparam int OffsetBits = $clog2(WordsPerLine) + 2;
  localparam int IndexBits  = $clog2(NrSets);
  localparam int TagBits    = AddrWidth - IndexBits - OffsetBits;
  localparam int LineSize   = 32 * WordsPerLine;
  localparam int WayBits    = (NrWays > 1) ? $clog2(NrWays) : 1;
  localparam int WordBits   = (WordsPerLine > 1) ? $clog2(WordsPerLine) : 1;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] REFILL = 1'b1;

  logic [0:0]            r_state;
  logic [NrWays-1:0]     r_valid [NrSets];
  logic [TagBits-1:0]    r_tag   [NrSets][NrWays];
  logic [LineSize-1:0]   r_data  [NrSets][NrWays];
  logic [WayBits-1:0]    r_ptr   [NrSets];
  logic [TagBits-1:0]    r_miss_tag;
  logic [IndexBits-1:0]  r_miss_idx;
  logic                  r_flush_pend;

  logic [TagBits-1:0]    w_tag;
  logic [IndexBits-1:0]  w_idx;
  logic [WordBits-1:0]   w_word;
  logic                  w_hit;
  logic [LineSize-1:0]   w_hit_line;
  logic                  w_read_valid;
  logic                  w_miss;
  logic [WayBits-1:0]    w_victim;
  logic                  w_all_valid;
  logic                  w_unused;

  assign w_tag    = addr_i[AddrWidth-1 -: TagBits];
  assign w_idx    = addr_i[OffsetBits +: IndexBits];
  assign w_unused = ^addr_i[1:0];

  generate
    if (WordsPerLine > 1) begin : g_word
      assign w_word = addr_i[OffsetBits-1:2];
    end else begin : g_word1
      assign w_word = '0;
    end
  endgenerate

  // Tag compare across the ways of the addressed set
  always_comb begin
    w_hit      = 1'b0;
    w_hit_line = '0;
    for (int w = 0; w < NrWays; w++) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit      = 1'b1;
        w_hit_line = r_data[w_idx][w];
      end
    end
  end

  // A pending flush forces a miss so the freshly refilled line is never returned
  assign w_read_valid = (r_state == IDLE) && read_en_i && w_hit && !r_flush_pend;
  assign w_miss       = (r_state == IDLE) && read_en_i && !w_read_valid;

  assign read_valid_o  = w_read_valid;
  assign read_word_o   = w_read_valid ? w_hit_line[32*w_word +: 32] : 32'd0;
  assign mem_read_en_o = (r_state == REFILL);
  assign mem_addr_o    = (r_state == REFILL) ? {r_miss_tag, r_miss_idx, {OffsetBits{1'b0}}}
                                             : {w_tag, w_idx, {OffsetBits{1'b0}}};

  // Victim choice for the miss set: lowest invalid way, else the round-robin pointer
  always_comb begin
    w_all_valid = 1'b1;
    w_victim    = r_ptr[r_miss_idx];
    for (int w = NrWays - 1; w >= 0; w--) begin
      if (!r_valid[r_miss_idx][w]) begin
        w_all_valid = 1'b0;
        w_victim    = WayBits'(w);
      end
    end
  end

  // Control state: FSM, valid bits, replacement pointers, miss registers, flush
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state      <= IDLE;
      r_flush_pend <= 1'b0;
      for (int s = 0; s < NrSets; s++) begin
        r_valid[s] <= '0;
        r_ptr[s]   <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (w_miss) begin
            r_miss_tag <= w_tag;
            r_miss_idx <= w_idx;
            r_state    <= REFILL;
          end
          if (flush_i || r_flush_pend) begin
            r_flush_pend <= 1'b0;
            for (int s = 0; s < NrSets; s++) begin
              r_valid[s] <= '0;
              r_ptr[s]   <= '0;
            end
          end
        end
        default: begin
          if (flush_i) r_flush_pend <= 1'b1;
          if (mem_read_valid_i) begin
            r_valid[r_miss_idx][w_victim] <= 1'b1;
            if (w_all_valid && (NrWays > 1)) r_ptr[r_miss_idx] <= WayBits'(r_ptr[r_miss_idx] + 1'b1);
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

  // Tag and line storage are not reset; only the valid bits qualify them
  always_ff @(posedge clk_i) begin
    if (rstn_i && (r_state == REFILL) && mem_read_valid_i) begin
      r_tag[r_miss_idx][w_victim]  <= r_miss_tag;
      r_data[r_miss_idx][w_victim] <= mem_read_data_i;
    end
  end

`ifdef CACHE_STATS_EN
  logic        r_was_miss;
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  // Hit counter skips the completion of a request that had to refill first
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_was_miss   <= 1'b0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_miss) begin
        r_miss_count <= r_miss_count + 32'd1;
        r_was_miss   <= 1'b1;
      end
      if (w_read_valid) begin
        if (!r_was_miss) r_hit_count <= r_hit_count + 32'd1;
        r_was_miss <= 1'b0;
      end
    end
  end

  assign hit_count_o  = r_hit_count;
  assign miss_count_o = r_miss_count;
`endif

endmodule

// File: tb/tb_cache_setassoc.sv
// Directed bench for cache_setassoc with default parameters (64 sets, 2 ways, 4 words).
module tb_cache_setassoc;

  logic         clk_i = 1'b0;
  logic         rstn_i = 1'b0;
  logic [31:0]  addr_i = '0;
  logic         read_en_i = 1'b0;
  logic         read_valid_o;
  logic [31:0]  read_word_o;
  logic         flush_i = 1'b0;
  logic [31:0]  mem_addr_o;
  logic         mem_read_en_o;
  logic         mem_read_valid_i = 1'b0;
  logic [127:0] mem_read_data_i = '0;
`ifdef CACHE_STATS_EN
  logic [31:0]  hit_count_o;
  logic [31:0]  miss_count_o;
`endif

  int n_total = 0;
  int n_bad   = 0;

  localparam logic [127:0] L100 = 128'h00000004_00000003_00000002_00000001;
  localparam logic [127:0] L000 = 128'h00000013_00000012_00000011_00000010;
  localparam logic [127:0] L400 = 128'h00000023_00000022_00000021_00000020;
  localparam logic [127:0] L800 = 128'h00000033_00000032_00000031_00000030;
  localparam logic [127:0] L200 = 128'h00000043_00000042_00000041_00000040;
  localparam logic [127:0] L500 = 128'h00000053_00000052_00000051_00000050;

  cache_setassoc dut (
    .clk_i            (clk_i),
    .rstn_i           (rstn_i),
    .addr_i           (addr_i),
    .read_en_i        (read_en_i),
    .read_valid_o     (read_valid_o),
    .read_word_o      (read_word_o),
    .flush_i          (flush_i),
    .mem_addr_o       (mem_addr_o),
    .mem_read_en_o    (mem_read_en_o),
    .mem_read_valid_i (mem_read_valid_i),
    .mem_read_data_i  (mem_read_data_i)
`ifdef CACHE_STATS_EN
    ,
    .hit_count_o      (hit_count_o),
    .miss_count_o     (miss_count_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Miss, then memory answers in refill cycle lat; the request hits one cycle later
  task automatic rd_miss(input logic [31:0] a, input logic [31:0] line_a, input int lat,
                         input logic [127:0] line, input logic [31:0] exp_word, input string tag);
    addr_i    = a;
    read_en_i = 1'b1;
    #1;
    chk({tag, "_miss_valid"}, {31'd0, read_valid_o}, 32'd0);
    chk({tag, "_miss_memen"}, {31'd0, mem_read_en_o}, 32'd0);
    for (int c = 1; c <= lat; c++) begin
      step();
      if (c == lat) begin
        mem_read_valid_i = 1'b1;
        mem_read_data_i  = line;
      end
      #1;
      chk({tag, "_refill_memen"}, {31'd0, mem_read_en_o}, 32'd1);
      chk({tag, "_refill_addr"}, mem_addr_o, line_a);
      chk({tag, "_refill_valid"}, {31'd0, read_valid_o}, 32'd0);
    end
    step();
    mem_read_valid_i = 1'b0;
    #1;
    chk({tag, "_done_valid"}, {31'd0, read_valid_o}, 32'd1);
    chk({tag, "_done_word"}, read_word_o, exp_word);
    chk({tag, "_done_memen"}, {31'd0, mem_read_en_o}, 32'd0);
    step();
    read_en_i = 1'b0;
  endtask

  task automatic rd_hit(input logic [31:0] a, input logic [31:0] exp_word, input string tag);
    addr_i    = a;
    read_en_i = 1'b1;
    #1;
    chk({tag, "_hit_valid"}, {31'd0, read_valid_o}, 32'd1);
    chk({tag, "_hit_word"}, read_word_o, exp_word);
    step();
    read_en_i = 1'b0;
  endtask

  initial begin
    // reset
    step();
    step();
    rstn_i = 1'b1;
    #1;
    chk("rst_valid", {31'd0, read_valid_o}, 32'd0);
    chk("rst_word", read_word_o, 32'd0);
    chk("rst_memen", {31'd0, mem_read_en_o}, 32'd0);
    step();

    // basic miss with 3-cycle memory, then hit to a different word of the line
    rd_miss(32'h100, 32'h100, 3, L100, 32'd1, "m100");
    rd_hit(32'h10C, 32'd4, "h10c");
    rd_hit(32'h104, 32'd2, "h104");

    // two ways of set 0, then round-robin eviction
    rd_miss(32'h000, 32'h000, 1, L000, 32'h10, "m000a");
    rd_miss(32'h404, 32'h400, 2, L400, 32'h21, "m404");
    rd_hit(32'h000, 32'h10, "h000a");
    rd_hit(32'h404, 32'h21, "h404a");
    rd_miss(32'h808, 32'h800, 1, L800, 32'h32, "m808");
    rd_hit(32'h404, 32'h21, "h404b");
    rd_miss(32'h000, 32'h000, 1, L000, 32'h10, "m000b");
    rd_hit(32'h808, 32'h32, "h808");
    rd_miss(32'h40C, 32'h400, 1, L400, 32'h23, "m40c");

    // flush pulse with no request, then the line misses
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    rd_miss(32'h000, 32'h000, 1, L000, 32'h10, "fl_m000");

    // flush coinciding with a hit still returns the data, next read misses
    flush_i = 1'b1;
    addr_i    = 32'h008;
    read_en_i = 1'b1;
    #1;
    chk("flhit_valid", {31'd0, read_valid_o}, 32'd1);
    chk("flhit_word", read_word_o, 32'h12);
    step();
    flush_i   = 1'b0;
    read_en_i = 1'b0;
    rd_miss(32'h008, 32'h000, 1, L000, 32'h12, "flhit_m008");

    // flush during refill: line lands, is invalidated, request refills again
    addr_i    = 32'h200;
    read_en_i = 1'b1;
    #1;
    chk("fr_miss_valid", {31'd0, read_valid_o}, 32'd0);
    step();
    flush_i = 1'b1;
    #1;
    chk("fr_memen1", {31'd0, mem_read_en_o}, 32'd1);
    chk("fr_addr1", mem_addr_o, 32'h200);
    step();
    flush_i          = 1'b0;
    mem_read_valid_i = 1'b1;
    mem_read_data_i  = L200;
    #1;
    chk("fr_memen2", {31'd0, mem_read_en_o}, 32'd1);
    step();
    mem_read_valid_i = 1'b0;
    #1;
    chk("fr_remiss_valid", {31'd0, read_valid_o}, 32'd0);
    chk("fr_remiss_memen", {31'd0, mem_read_en_o}, 32'd0);
    step();
    #1;
    chk("fr_memen3", {31'd0, mem_read_en_o}, 32'd1);
    chk("fr_addr3", mem_addr_o, 32'h200);
    step();
    mem_read_valid_i = 1'b1;
    #1;
    step();
    mem_read_valid_i = 1'b0;
    #1;
    chk("fr_done_valid", {31'd0, read_valid_o}, 32'd1);
    chk("fr_done_word", read_word_o, 32'h40);
    step();
    read_en_i = 1'b0;

    // reset during refill abandons it; late memory pulse is ignored
    addr_i    = 32'h300;
    read_en_i = 1'b1;
    step();
    #1;
    chk("rr_memen", {31'd0, mem_read_en_o}, 32'd1);
    rstn_i    = 1'b0;
    read_en_i = 1'b0;
    step();
    rstn_i = 1'b1;
    #1;
    chk("rr_memen_off", {31'd0, mem_read_en_o}, 32'd0);
    mem_read_valid_i = 1'b1;
    mem_read_data_i  = L000;
    step();
    mem_read_valid_i = 1'b0;
    #1;
    chk("rr_ign_memen", {31'd0, mem_read_en_o}, 32'd0);
    chk("rr_ign_valid", {31'd0, read_valid_o}, 32'd0);
    rd_miss(32'h000, 32'h000, 1, L000, 32'h10, "rr_m000");

    // statistics: one miss followed by three hits
    rstn_i = 1'b0;
    step();
    rstn_i = 1'b1;
    rd_miss(32'h500, 32'h500, 2, L500, 32'h50, "st_m500");
    rd_hit(32'h500, 32'h50, "st_h1");
    rd_hit(32'h504, 32'h51, "st_h2");
    rd_hit(32'h508, 32'h52, "st_h3");
`ifdef CACHE_STATS_EN
    chk("st_miss_count", miss_count_o, 32'd1);
    chk("st_hit_count", hit_count_o, 32'd3);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
